// File: rtl/fir_out_fifo.sv
// fir_out_fifo: rounds/saturates FIR results and buffers them in a FWFT FIFO with valid/ready drain.
module fir_out_fifo #(
  parameter int IN_W  = 29,
  parameter int OUT_W = 16,
  parameter int SHIFT = 12,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic [IN_W-1:0]  yout,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CW-1:0]    fifo_count,
  output logic             overflow,
  input  logic             overflow_clr
);
  localparam int AW = CW - 1;
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] MAXV = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = ~MAXV;
  logic signed [IN_W:0] sum, q;
  logic [OUT_W-1:0] sat, s;
  logic stage_vld;
  logic [OUT_W-1:0] mem [DEPTH];
  logic [CW-1:0] wr_ptr, rd_ptr;
  logic full, empty, pop, wr, drop;
  always_comb begin
    sum = $signed({yout[IN_W-1], yout}) + HALF;
    q = sum >>> SHIFT;
    sat = q > MAXV ? MAXV[OUT_W-1:0] : q < MINV ? MINV[OUT_W-1:0] : q[OUT_W-1:0];
  end
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[CW-1] != rd_ptr[CW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop = !empty && dout_ready;
  // a pop frees the very slot a full-FIFO write lands in, so both can happen together
  assign wr = stage_vld && (!full || pop);
  assign drop = stage_vld && full && !pop;
  assign dout_valid = !empty;
  assign dout = dout_valid ? mem[rd_ptr[AW-1:0]] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
      stage_vld <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
    end else begin
      s <= rdy ? sat : s;
      stage_vld <= rdy;
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      fifo_count <= fifo_count + CW'(wr) - CW'(pop);
      overflow <= drop ? 1'b1 : overflow_clr ? 1'b0 : overflow;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= s;
  end
endmodule

// File: tb/tb_fir_out_fifo.sv
// tb_fir_out_fifo: directed vectors for rounding, saturation, cadence, overflow, full+pop and reset.
module tb_fir_out_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0;
  logic [28:0] yout = '0;
  logic [15:0] dout;
  logic dout_valid;
  logic dout_ready = 1'b0;
  logic [3:0] fifo_count;
  logic overflow;
  logic overflow_clr = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [28:0] rv [8];
  logic [15:0] re [8];
  int maxc;

  fir_out_fifo dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .yout(yout), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .fifo_count(fifo_count),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [28:0] y);
    rdy = 1'b1;
    yout = y;
    tick();
    rdy = 1'b0;
  endtask

  initial begin
    rv[0] = 29'd2048;       re[0] = 16'h0001;
    rv[1] = 29'd20480;      re[1] = 16'h0005;
    rv[2] = 29'h1FFFF800;   re[2] = 16'h0000;
    rv[3] = 29'h1FFFF7FF;   re[3] = 16'hFFFF;
    rv[4] = 29'd2047;       re[4] = 16'h0000;
    rv[5] = 29'h08000000;   re[5] = 16'h7FFF;
    rv[6] = 29'h0FFFFFFF;   re[6] = 16'h7FFF;
    rv[7] = 29'h10000000;   re[7] = 16'h8000;
    #12;
    check("rst_valid", 32'(dout_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_dout", 32'(dout), 0);
    rst_n = 1'b1;
    dout_ready = 1'b1;
    tick();
    check("empty_pop_count", 32'(fifo_count), 0);
    for (int i = 0; i < 8; i++) begin
      strobe(rv[i]);
      check("rnd_stage_valid", 32'(dout_valid), 0);
      tick();
      check("rnd_valid", 32'(dout_valid), 1);
      check("rnd_dout", 32'(dout), 32'(re[i]));
      tick();
      check("rnd_drained", 32'(dout_valid), 0);
      check("rnd_ovf", 32'(overflow), 0);
    end
    maxc = 0;
    for (int k = 1; k <= 4; k++) begin
      strobe(29'(k * 4096));
      maxc = fifo_count > maxc ? int'(fifo_count) : maxc;
      tick();
      maxc = fifo_count > maxc ? int'(fifo_count) : maxc;
      check("cad_valid", 32'(dout_valid), 1);
      check("cad_dout", 32'(dout), 32'(k));
      for (int j = 0; j < 6; j++) begin
        tick();
        maxc = fifo_count > maxc ? int'(fifo_count) : maxc;
      end
      check("cad_drop", 32'(dout_valid), 0);
    end
    check("cad_max", 32'(maxc), 1);
    dout_ready = 1'b0;
    for (int k = 1; k <= 9; k++) strobe(29'(k * 4096));
    tick();
    check("fill_count", 32'(fifo_count), 8);
    check("fill_ovf", 32'(overflow), 1);
    tick();
    check("ovf_sticky", 32'(overflow), 1);
    dout_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("drain_dout", 32'(dout), 32'(k));
      tick();
    end
    dout_ready = 1'b0;
    check("drain_empty", 32'(dout_valid), 0);
    check("drain_count", 32'(fifo_count), 0);
    check("drain_ovf", 32'(overflow), 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 0);
    for (int k = 1; k <= 8; k++) strobe(29'(k * 4096));
    tick();
    check("full_count", 32'(fifo_count), 8);
    strobe(29'(100 * 4096));
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("fullpop_count", 32'(fifo_count), 8);
    check("fullpop_ovf", 32'(overflow), 0);
    check("fullpop_head", 32'(dout), 2);
    dout_ready = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      check("fullpop_dout", 32'(dout), k == 9 ? 32'd100 : 32'(k));
      tick();
    end
    dout_ready = 1'b0;
    check("fullpop_empty", 32'(dout_valid), 0);
    for (int k = 1; k <= 5; k++) strobe(29'(k * 4096));
    tick();
    strobe(29'(7 * 4096));
    check("pre_rst_count", 32'(fifo_count), 5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(dout_valid), 0);
    check("mid_rst_count", 32'(fifo_count), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    #1 rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_empty", 32'(dout_valid), 0);
    strobe(29'(3 * 4096));
    tick();
    check("post_rst_valid", 32'(dout_valid), 1);
    check("post_rst_dout", 32'(dout), 3);
    check("post_rst_count", 32'(fifo_count), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
